// File: rtl/mono_run_ctrl.sv
// Run/halt/step sequencer for the mono core: gates commit via core_en,
// handles PC breakpoints, EBREAK stops, counted runs and retired counting.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   S_HALTED | core frozen, waiting for RUN / STEP / RUN_N
//   S_RUN    | free-run until HALT, breakpoint or EBREAK
//   S_RUN_N  | run until remaining reaches zero (or other stop)
module mono_run_ctrl #(
    parameter int NUM_BP = 2,
    parameter int CNT_W  = 32,
    localparam int SEL_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_op,
    input  logic [31:0]      cmd_arg,
    input  logic [SEL_W-1:0] cmd_bp_sel,
    output logic             cmd_err,
    input  logic [31:0]      pc,
    input  logic             ebreak,
    output logic             core_en,
    output logic             halted,
    output logic             halt_pulse,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {S_HALTED, S_RUN, S_RUN_N} state_t;

    localparam logic [2:0] OP_HALT   = 3'd1;
    localparam logic [2:0] OP_RUN    = 3'd2;
    localparam logic [2:0] OP_STEP   = 3'd3;
    localparam logic [2:0] OP_RUN_N  = 3'd4;
    localparam logic [2:0] OP_SET_BP = 3'd5;
    localparam logic [2:0] OP_CLR_BP = 3'd6;
    localparam logic [2:0] OP_BAD    = 3'd7;

    localparam logic [1:0] CAUSE_CMD   = 2'd0;
    localparam logic [1:0] CAUSE_COUNT = 2'd1;
    localparam logic [1:0] CAUSE_BP    = 2'd2;
    localparam logic [1:0] CAUSE_EBRK  = 2'd3;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   remaining, remaining_nxt;
    logic               skip_bp, skip_nxt;
    logic [1:0]         cause_nxt;
    logic               pulse_nxt, err_nxt;
    logic [31:0]        bp_pc [NUM_BP];
    logic [NUM_BP-1:0]  bp_valid;
    logic               bp_wr, bp_wr_valid;
    logic               bp_match, bp_stop;
    logic               sel_ok, exit_now;
    logic [1:0]         exit_cause;
    logic [CNT_W-1:0]   arg_cnt;

    assign arg_cnt = cmd_arg[CNT_W-1:0];
    assign sel_ok  = int'(cmd_bp_sel) < NUM_BP;

    always_comb begin
        bp_match = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_valid[i] && (bp_pc[i] == pc)) bp_match = 1'b1;
        end
    end

    // skip_bp lets a resume from a breakpoint PC execute that instruction once
    assign bp_stop = bp_match && !skip_bp;
    assign core_en = (state != S_HALTED) && !bp_stop;
    assign halted  = (state == S_HALTED);

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        skip_nxt      = skip_bp;
        cause_nxt     = halt_cause;
        pulse_nxt     = 1'b0;
        err_nxt       = 1'b0;
        bp_wr         = 1'b0;
        bp_wr_valid   = 1'b0;
        exit_now      = 1'b0;
        exit_cause    = CAUSE_CMD;

        if (cmd_valid) begin
            case (cmd_op)
                OP_SET_BP, OP_CLR_BP: begin
                    if (sel_ok) begin
                        bp_wr       = 1'b1;
                        bp_wr_valid = (cmd_op == OP_SET_BP);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                OP_BAD:  err_nxt = 1'b1;
                default: ;
            endcase
        end

        case (state)
            S_HALTED: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_RUN: begin
                            state_nxt = S_RUN;
                            skip_nxt  = 1'b1;
                        end
                        OP_STEP: begin
                            state_nxt     = S_RUN_N;
                            remaining_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
                            skip_nxt      = 1'b1;
                        end
                        OP_RUN_N: begin
                            if (arg_cnt == '0) begin
                                err_nxt = 1'b1;
                            end else begin
                                state_nxt     = S_RUN_N;
                                remaining_nxt = arg_cnt;
                                skip_nxt      = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                if (cmd_valid && ((cmd_op == OP_RUN) || (cmd_op == OP_STEP) ||
                                  (cmd_op == OP_RUN_N)))
                    err_nxt = 1'b1;
                if (core_en) begin
                    skip_nxt = 1'b0;
                    if (state == S_RUN_N) remaining_nxt = remaining - 1'b1;
                end
                if (cmd_valid && (cmd_op == OP_HALT)) begin
                    exit_now   = 1'b1;
                    exit_cause = CAUSE_CMD;
                end else if (bp_stop) begin
                    exit_now   = 1'b1;
                    exit_cause = CAUSE_BP;
                end else if (core_en && ebreak) begin
                    exit_now   = 1'b1;
                    exit_cause = CAUSE_EBRK;
                end else if ((state == S_RUN_N) && core_en &&
                             (remaining == {{(CNT_W-1){1'b0}}, 1'b1})) begin
                    exit_now   = 1'b1;
                    exit_cause = CAUSE_COUNT;
                end
                if (exit_now) begin
                    state_nxt = S_HALTED;
                    pulse_nxt = 1'b1;
                    cause_nxt = exit_cause;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_HALTED;
            remaining  <= '0;
            skip_bp    <= 1'b0;
            halt_cause <= CAUSE_CMD;
            halt_pulse <= 1'b0;
            cmd_err    <= 1'b0;
            retired    <= '0;
            bp_valid   <= '0;
            for (int i = 0; i < NUM_BP; i++) bp_pc[i] <= '0;
        end else begin
            state      <= state_nxt;
            remaining  <= remaining_nxt;
            skip_bp    <= skip_nxt;
            halt_cause <= cause_nxt;
            halt_pulse <= pulse_nxt;
            cmd_err    <= err_nxt;
            retired    <= retired + {{(CNT_W-1){1'b0}}, core_en};
            for (int i = 0; i < NUM_BP; i++) begin
                if (bp_wr && (int'(cmd_bp_sel) == i)) begin
                    bp_valid[i] <= bp_wr_valid;
                    if (bp_wr_valid) bp_pc[i] <= cmd_arg;
                end
            end
        end
    end

endmodule

// File: doc/mono_run_ctrl.md
Name: mono_run_ctrl

Overview:
- Run/halt/step sequencer for the single-cycle `mono` core.
- Drives a commit-enable (`core_en`) that gates PC update, register-unit writes and memory writes.
- Lets a host or testbench halt, single-step, run N instructions or free-run the core, with PC breakpoints and EBREAK stop.
- Sits between the host command interface and the core datapath; counts retired instructions.

Parameters:
- NUM_BP, 2, number of PC breakpoint comparators (1..8).
- CNT_W, 32, width of the retired-instruction counter and the RUN_N count.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; synchronous, active-low
- cmd_valid  in  1  host command strobe
- cmd_op  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 RUN_N, 5 SET_BP, 6 CLR_BP
- cmd_arg  in  32  RUN_N count (low CNT_W bits) or breakpoint PC
- cmd_bp_sel  in  $clog2(NUM_BP) (min 1)  breakpoint index for SET_BP/CLR_BP
- cmd_err  out  1  one-cycle pulse: command rejected
- pc  in  32  current core PC (instruction executing this cycle)
- ebreak  in  1  decoder flag: current instruction is EBREAK
- core_en  out  1  combinational; 1 = core commits this cycle's instruction at the next rising edge
- halted  out  1  registered; 1 in HALTED state
- halt_pulse  out  1  one-cycle pulse on the edge entering HALTED (not on reset)
- halt_cause  out  2  0 CMD/RESET, 1 COUNT_DONE, 2 BREAKPOINT, 3 EBREAK
- retired  out  CNT_W  instructions committed since reset; wraps modulo 2^CNT_W

Behaviour:
- Clock/reset: one clock `clk`. Reset is synchronous, active-low `rst_n`; it overrides everything.
- Reset values:
  - state HALTED, halted=1, halt_cause=0, halt_pulse=0, cmd_err=0, retired=0.
  - All breakpoints invalid; skip_bp=0; remaining=0.
  - core_en=0 (follows from state).
- States: HALTED, RUN (free-run), RUN_N (counted).
- core_en = (state != HALTED) && !(bp_match && !skip_bp).
  - bp_match = any valid bp[i] == pc.
- skip_bp:
  - Set on every HALTED -> RUN/RUN_N transition.
  - Cleared on the first cycle with core_en=1.
  - Effect: resuming from a breakpoint PC executes that instruction.
- Commands are sampled at the rising edge when cmd_valid=1. They never affect core_en in the same cycle.
- HALTED state:
  - RUN -> RUN.
  - STEP -> RUN_N with remaining=1.
  - RUN_N -> RUN_N with remaining=cmd_arg; cmd_arg==0 gives cmd_err and stays HALTED.
  - HALT/NOP -> no change, no error.
- RUN/RUN_N state:
  - HALT -> HALTED, cause 0. The instruction executing in the HALT cycle still commits if core_en=1.
  - RUN/STEP/RUN_N -> cmd_err, ignored.
- SET_BP/CLR_BP are legal in any state and take effect from the next cycle.
  - SET_BP writes bp[sel]=cmd_arg and marks it valid; CLR_BP invalidates bp[sel].
  - sel >= NUM_BP -> cmd_err, no change.
- Opcode 7 -> cmd_err.
- Each cycle with core_en=1: retired += 1; in RUN_N, remaining -= 1.
- Exit to HALTED at the edge ending cycle t; priority top to bottom:
  1. HALT cmd -> cause 0.
  2. Breakpoint suppression (core_en=0 due to bp) -> cause 2; nothing commits.
  3. core_en=1 && ebreak -> cause 3; the EBREAK commits and the PC advances past it.
  4. RUN_N, core_en=1, remaining==1 -> cause 1.
- halt_pulse=1 in the cycle after the transition edge. halt_cause holds until the next transition.
- A mid-operation rst_n=0 forces HALTED without halt_pulse and clears the breakpoints.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> halted=1, core_en=0, retired=0, halt_pulse=0, cause=0.
- STEP from HALTED -> core_en=1 for exactly 1 cycle; retired=1; halt_pulse next cycle; cause=1.
- RUN_N arg=5 -> 5 consecutive core_en cycles, retired=5, cause=1. Then RUN_N arg=0 -> cmd_err pulse, stays halted.
- SET_BP sel=0 arg=0x0000_0010, then RUN with pc stepping 0x0,0x4,... -> core_en=0 when pc=0x10; retired=4; cause=2. RUN again -> 0x10 commits; run continues.
- RUN, EBREAK at pc=0x8 -> EBREAK commits (retired=3); halted; cause=3. Also: HALT cmd in the same cycle as ebreak -> cause=0.
- While running, issue RUN -> cmd_err=1 for 1 cycle, run unaffected. Assert rst_n=0 mid-RUN_N -> HALTED next edge, bp cleared, retired=0.
